// File: rtl/tl_pkg.sv
// Shared encodings for the multi-approach traffic controller:
// lamp patterns, FSM state codes and a width helper.
package tl_pkg;

  typedef logic [2:0] lamp_t;

  localparam lamp_t RED       = 3'b100;
  localparam lamp_t YELLOW    = 3'b010;
  localparam lamp_t GREEN     = 3'b001;
  localparam lamp_t DONT_WALK = 3'b100;
  localparam lamp_t CLEAR     = 3'b010;
  localparam lamp_t WALK      = 3'b001;
  localparam lamp_t DARK      = 3'b000;

  localparam logic [2:0] ST_ALL_RED   = 3'd0;
  localparam logic [2:0] ST_GREEN     = 3'd1;
  localparam logic [2:0] ST_YELLOW    = 3'd2;
  localparam logic [2:0] ST_EMG_GREEN = 3'd3;
  localparam logic [2:0] ST_FLASH     = 3'd4;

  // Never returns less than 1, so a 1-approach select still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++)
      if ((1 << k) < n) r = k + 1;
    return r;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter used as the phase timer; holds at zero
// until reloaded, done flags the terminal count.
module tl_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= RST_VAL;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic controller for NUM_DIR approaches with latched
// walker requests, emergency preemption and night flashing.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ALL_RED    | clearance; picks GREEN, EMG_GREEN or FLASH on expiry
//   GREEN      | cur_dir green, optional WALK then CLEAR
//   YELLOW     | cur_dir yellow, served walker shows CLEAR
//   EMG_GREEN  | latched emergency approach green while emg_req held
//   FLASH      | car 0 yellow / others red blinking, walkers dark
module traffic_ctrl_multi
  import tl_pkg::*;
#(
  parameter int NUM_DIR     = 2,
  parameter int GREEN_CYC   = 20,
  parameter int YELLOW_CYC  = 4,
  parameter int ALL_RED_CYC = 2,
  parameter int WALK_CYC    = 8,
  parameter int FLASH_CYC   = 5,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DIR-1:0]         ped_req,
  input  logic                       emg_req,
  input  logic [clog2(NUM_DIR)-1:0]  emg_dir,
  input  logic                       flash_mode,
  output logic [3*NUM_DIR-1:0]       car_light,
  output logic [3*NUM_DIR-1:0]       walker_light,
  output logic [clog2(NUM_DIR)-1:0]  cur_dir,
  output logic [2:0]                 state_o
);

  localparam int               DIR_W      = clog2(NUM_DIR);
  localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(NUM_DIR - 1);
  localparam logic [CNT_W-1:0] T_GREEN    = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] T_YELLOW   = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] T_ALL_RED  = CNT_W'(ALL_RED_CYC - 1);
  localparam logic [CNT_W-1:0] T_FLASH    = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] T_WALK_END = CNT_W'(GREEN_CYC - WALK_CYC);

  logic [2:0]         state, state_n;
  logic [DIR_W-1:0]   dir_n, emg_dir_q, emg_dir_n, tgt_dir;
  logic [NUM_DIR-1:0] ped_pend, ped_pend_n;
  logic               serve, serve_n;
  logic               emg_act, emg_act_n;
  logic               flash_on, flash_on_n;
  logic               t_load, t_done;
  logic [CNT_W-1:0]   t_val, t_count;

  tl_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (T_ALL_RED)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .done     (t_done)
  );

  assign tgt_dir = emg_act ? emg_dir_q : emg_dir;

  always_comb begin
    state_n    = state;
    dir_n      = cur_dir;
    serve_n    = serve;
    emg_act_n  = emg_act;
    emg_dir_n  = emg_dir_q;
    flash_on_n = flash_on;
    ped_pend_n = ped_pend | ped_req;
    t_load     = 1'b0;
    t_val      = '0;

    // The first cycle of a request fixes which approach gets preempted.
    if (emg_req && !emg_act) begin
      emg_act_n = 1'b1;
      emg_dir_n = emg_dir;
    end

    case (state)
      ST_ALL_RED: begin
        if (t_done) begin
          if (emg_act || emg_req) begin
            state_n = ST_EMG_GREEN;
            dir_n   = tgt_dir;
            serve_n = 1'b0;
          end else if (flash_mode) begin
            state_n    = ST_FLASH;
            flash_on_n = 1'b1;
            t_load     = 1'b1;
            t_val      = T_FLASH;
          end else begin
            state_n             = ST_GREEN;
            t_load              = 1'b1;
            t_val               = T_GREEN;
            serve_n             = ped_pend[cur_dir];
            ped_pend_n[cur_dir] = ped_req[cur_dir];
          end
        end
      end
      ST_GREEN: begin
        if (emg_req && emg_dir == cur_dir) begin
          state_n = ST_EMG_GREEN;
          serve_n = 1'b0;
        end else if (emg_req || t_done) begin
          state_n = ST_YELLOW;
          t_load  = 1'b1;
          t_val   = T_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (t_done) begin
          state_n = ST_ALL_RED;
          t_load  = 1'b1;
          t_val   = T_ALL_RED;
          serve_n = 1'b0;
          dir_n   = (cur_dir == LAST_DIR) ? '0 : cur_dir + 1'b1;
        end
      end
      ST_EMG_GREEN: begin
        if (!emg_req) begin
          state_n   = ST_YELLOW;
          t_load    = 1'b1;
          t_val     = T_YELLOW;
          emg_act_n = 1'b0;
        end
      end
      ST_FLASH: begin
        if (emg_req) begin
          state_n = ST_ALL_RED;
          t_load  = 1'b1;
          t_val   = T_ALL_RED;
        end else if (t_done) begin
          t_load = 1'b1;
          if (!flash_mode) begin
            state_n = ST_ALL_RED;
            t_val   = T_ALL_RED;
            dir_n   = '0;
          end else begin
            flash_on_n = ~flash_on;
            t_val      = T_FLASH;
          end
        end
      end
      default: begin
        state_n = ST_ALL_RED;
        t_load  = 1'b1;
        t_val   = T_ALL_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ALL_RED;
      cur_dir   <= '0;
      ped_pend  <= '0;
      serve     <= 1'b0;
      emg_act   <= 1'b0;
      emg_dir_q <= '0;
      flash_on  <= 1'b1;
    end else begin
      state     <= state_n;
      cur_dir   <= dir_n;
      ped_pend  <= ped_pend_n;
      serve     <= serve_n;
      emg_act   <= emg_act_n;
      emg_dir_q <= emg_dir_n;
      flash_on  <= flash_on_n;
    end
  end

  always_comb begin
    car_light    = '0;
    walker_light = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      car_light[3*i +: 3]    = RED;
      walker_light[3*i +: 3] = DONT_WALK;
      case (state)
        ST_GREEN: begin
          if (DIR_W'(i) == cur_dir) begin
            car_light[3*i +: 3] = GREEN;
            if (serve)
              walker_light[3*i +: 3] = (t_count >= T_WALK_END) ? WALK : CLEAR;
          end
        end
        ST_YELLOW: begin
          if (DIR_W'(i) == cur_dir) begin
            car_light[3*i +: 3] = YELLOW;
            if (serve) walker_light[3*i +: 3] = CLEAR;
          end
        end
        ST_EMG_GREEN: begin
          if (DIR_W'(i) == cur_dir) car_light[3*i +: 3] = GREEN;
        end
        ST_FLASH: begin
          car_light[3*i +: 3]    = !flash_on ? DARK : (i == 0) ? YELLOW : RED;
          walker_light[3*i +: 3] = DARK;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: directed scenarios plus a randomized run,
// all cycles of the 2-approach instance compared with a phase-level model.
module tb_traffic_ctrl_multi;

  localparam int ND = 2;
  localparam int G  = 20;
  localparam int Y  = 4;
  localparam int AR = 2;
  localparam int W  = 8;
  localparam int F  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ped_req;
  logic       emg_req;
  logic [0:0] emg_dir;
  logic       flash_mode;
  logic [5:0] car_light, walker_light;
  logic [0:0] cur_dir;
  logic [2:0] state_o;

  logic [2:0] ped3;
  logic       emg3;
  logic [1:0] edir3;
  logic       flash3;
  logic [8:0] car3, walk3;
  logic [1:0] dir3;
  logic [2:0] st3;

  always #5 clk = ~clk;

  traffic_ctrl_multi dut (
    .clk          (clk),
    .reset        (reset),
    .ped_req      (ped_req),
    .emg_req      (emg_req),
    .emg_dir      (emg_dir),
    .flash_mode   (flash_mode),
    .car_light    (car_light),
    .walker_light (walker_light),
    .cur_dir      (cur_dir),
    .state_o      (state_o)
  );

  traffic_ctrl_multi #(.NUM_DIR(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .ped_req      (ped3),
    .emg_req      (emg3),
    .emg_dir      (edir3),
    .flash_mode   (flash3),
    .car_light    (car3),
    .walker_light (walk3),
    .cur_dir      (dir3),
    .state_o      (st3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  // Model: phase kind (0 all-red,1 green,2 yellow,3 emergency,4 flash),
  // cycles elapsed in the phase, owner, next owner, pending walkers.
  int m_st, m_age, m_dir, m_next, m_edir;
  bit m_pend[ND];
  bit m_serve, m_emg, m_fon;

  function automatic int dur(input int s);
    case (s)
      0: return AR;
      1: return G;
      2: return Y;
      4: return F;
      default: return 1;
    endcase
  endfunction

  function automatic void go(input int s);
    m_st  = s;
    m_age = 0;
  endfunction

  function automatic logic [5:0] exp_car();
    logic [5:0] v;
    logic [2:0] l;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      l = 3'b100;
      if ((m_st == 1 || m_st == 3) && i == m_dir) l = 3'b001;
      else if (m_st == 2 && i == m_dir) l = 3'b010;
      else if (m_st == 4) l = !m_fon ? 3'b000 : (i == 0) ? 3'b010 : 3'b100;
      v[3*i +: 3] = l;
    end
    return v;
  endfunction

  function automatic logic [5:0] exp_walk();
    logic [5:0] v;
    logic [2:0] l;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      l = 3'b100;
      if (m_st == 4) l = 3'b000;
      else if (m_st == 1 && i == m_dir && m_serve) l = (m_age < W) ? 3'b001 : 3'b010;
      else if (m_st == 2 && i == m_dir && m_serve) l = 3'b010;
      v[3*i +: 3] = l;
    end
    return v;
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] ped, input bit emg,
                            input int edir, input bit flash);
    bit last;
    bit old[ND];
    if (rst) begin
      m_st = 0; m_age = 0; m_dir = 0; m_next = 0; m_edir = 0;
      m_serve = 0; m_emg = 0; m_fon = 1;
      for (int i = 0; i < ND; i++) m_pend[i] = 0;
      return;
    end
    last = (m_age >= dur(m_st) - 1);
    m_age++;
    old = m_pend;
    for (int i = 0; i < ND; i++) m_pend[i] = m_pend[i] | ped[i];
    case (m_st)
      0: begin
        if (emg && !m_emg) begin m_emg = 1; m_edir = edir; end
        if (last) begin
          if (m_emg) begin go(3); m_dir = m_edir; m_serve = 0; end
          else if (flash) begin go(4); m_fon = 1; end
          else begin
            go(1);
            m_dir = m_next;
            m_serve = old[m_dir];
            m_pend[m_dir] = ped[m_dir];
          end
        end
      end
      1: begin
        if (emg) begin
          m_emg = 1; m_edir = edir;
          if (edir == m_dir) begin go(3); m_serve = 0; end
          else go(2);
        end else if (last) go(2);
      end
      2: begin
        if (emg && !m_emg) begin m_emg = 1; m_edir = edir; end
        if (last) begin go(0); m_next = (m_dir + 1) % ND; m_serve = 0; end
      end
      3: begin
        if (!emg) begin go(2); m_emg = 0; end
      end
      default: begin
        if (emg) begin
          if (!m_emg) begin m_emg = 1; m_edir = edir; end
          go(0);
        end else if (last) begin
          if (!flash) begin go(0); m_next = 0; end
          else begin m_fon = !m_fon; m_age = 0; end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, want);
    end
  endtask

  task automatic tick();
    if (chk_en) begin
      check("m_state", state_o, m_st);
      check("m_car", car_light, exp_car());
      check("m_walker", walker_light, exp_walk());
      if (m_st >= 1 && m_st <= 3) check("m_cur_dir", cur_dir, m_dir);
    end
    model_step(reset, ped_req, emg_req, emg_dir, flash_mode);
    @(negedge clk);
    cyc++;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1; ped_req = 0; emg_req = 0; emg_dir = 0; flash_mode = 0;
    ped3 = 0; emg3 = 0; edir3 = 0; flash3 = 0;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    cyc = 0;
  endtask

  initial begin
    // Reset, rotation and walker service
    do_reset();
    at(0);  check("A_car0", car_light, 6'b100100); check("A_walk0", walker_light, 6'b100100);
            check("A_st0", state_o, 0);
    at(1);  check("A_car1", car_light, 6'b100100);
    at(2);  check("A_car2", car_light, 6'b100001); check("A_dir2", cur_dir, 0);
    at(5);  ped_req = 2'b10; tick(); ped_req = 0;
    at(21); check("A_car21", car_light, 6'b100001);
    at(22); check("A_car22", car_light, 6'b100010);
    at(25); check("A_car25", car_light, 6'b100010);
    at(26); check("A_car26", car_light, 6'b100100);
    at(27); check("A_car27", car_light, 6'b100100);
    at(28); check("A_car28", car_light, 6'b001100); check("A_walk28", walker_light, 6'b001100);
            check("A_dir28", cur_dir, 1);
    at(35); check("A_walk35", walker_light, 6'b001100);
    at(36); check("A_walk36", walker_light, 6'b010100);
    at(51); check("A_walk51", walker_light, 6'b010100); check("A_car51", car_light, 6'b010100);
    at(52); check("A_walk52", walker_light, 6'b100100);
    at(54); check("A_car54", car_light, 6'b100001); check("A_walk54", walker_light, 6'b100100);

    // Reset in the middle of yellow
    do_reset();
    at(5);  ped_req = 2'b01; tick(); ped_req = 0;
    at(23); reset = 1; tick();
    check("B_car24", car_light, 6'b100100); check("B_st24", state_o, 0);
    reset = 0; cyc = 0;
    at(1);  check("B_car1", car_light, 6'b100100);
    at(2);  check("B_car2", car_light, 6'b100001); check("B_walk2", walker_light, 6'b100100);
    at(22); check("B_car22", car_light, 6'b100010);

    // Emergency preemption
    do_reset();
    at(10); emg_req = 1; emg_dir = 1;
    at(11); check("C_car11", car_light, 6'b100010); check("C_st11", state_o, 2);
    at(14); check("C_car14", car_light, 6'b100010);
    at(15); check("C_car15", car_light, 6'b100100);
    at(16); check("C_car16", car_light, 6'b100100);
    at(17); check("C_car17", car_light, 6'b001100); check("C_st17", state_o, 3);
            check("C_dir17", cur_dir, 1);
    at(20); emg_dir = 0;
    at(30); check("C_car30", car_light, 6'b001100);
    at(40); emg_req = 0;
    at(41); check("C_car41", car_light, 6'b010100); check("C_st41", state_o, 2);
    at(44); check("C_car44", car_light, 6'b010100);
    at(45); check("C_car45", car_light, 6'b100100);
    at(47); check("C_car47", car_light, 6'b100001); check("C_dir47", cur_dir, 0);

    // Flash mode
    do_reset();
    at(5);  flash_mode = 1;
    at(27); check("D_car27", car_light, 6'b100100);
    at(28); check("D_st28", state_o, 4); check("D_car28", car_light, 6'b100010);
            check("D_walk28", walker_light, 6'b000000);
    at(32); check("D_car32", car_light, 6'b100010);
    at(33); check("D_car33", car_light, 6'b000000);
    at(35); flash_mode = 0;
    at(37); check("D_car37", car_light, 6'b000000);
    at(38); check("D_car38", car_light, 6'b100100); check("D_st38", state_o, 0);
    at(39); check("D_car39", car_light, 6'b100100);
    at(40); check("D_car40", car_light, 6'b100001); check("D_dir40", cur_dir, 0);

    // Three approaches: rotation order
    do_reset();
    at(2);  check("E_car2", car3, 9'b100100001);
    at(28); check("E_car28", car3, 9'b100001100); check("E_dir28", dir3, 1);
    at(54); check("E_car54", car3, 9'b001100100); check("E_dir54", dir3, 2);
    at(80); check("E_car80", car3, 9'b100100001); check("E_dir80", dir3, 0);

    // Three approaches: emergency for the approach already green
    do_reset();
    at(60); emg3 = 1; edir3 = 2;
    at(61); check("E_st61", st3, 3); check("E_car61", car3, 9'b001100100);
            check("E_dir61", dir3, 2);
    at(70); emg3 = 0;
    at(71); check("E_st71", st3, 2); check("E_car71", car3, 9'b010100100);
    at(75); check("E_car75", car3, 9'b100100100);
    at(77); check("E_car77", car3, 9'b100100001);

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      ped_req = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 199) == 0) flash_mode = ~flash_mode;
      if (!emg_req) begin
        if ($urandom_range(0, 249) == 0) begin
          emg_req = 1;
          emg_dir = 1'($urandom);
        end
      end else begin
        if ($urandom_range(0, 3) == 0) emg_dir = 1'($urandom);
        if (m_st == 3 && $urandom_range(0, 15) == 0) emg_req = 0;
      end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised successor to the two-road `traffic` controller. It drives NUM_DIR approaches, each with one car light and one walker light, and sequences green phases round-robin with per-phase cycle counts. It adds latched pedestrian requests, emergency-vehicle preemption and a night flashing mode. It sits at the top of the intersection design and is driven straight from the system clock.

## Interface
- NUM_DIR, 2: number of approaches, 2..4.
- GREEN_CYC, 20: car green duration, cycles.
- YELLOW_CYC, 4: car yellow duration, cycles.
- ALL_RED_CYC, 2: all-red clearance between phases, cycles.
- WALK_CYC, 8: walker WALK duration. Must be less than GREEN_CYC.
- FLASH_CYC, 5: half-period of the flashing mode, cycles.
- CNT_W, 8: phase-timer width. Every *_CYC value must be ≤ 2^CNT_W.
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ped_req  in  NUM_DIR  walker button per approach, level or pulse.
- emg_req  in  1  emergency preemption request, held for the whole preemption.
- emg_dir  in  $clog2(NUM_DIR)  approach to serve during preemption; sampled with emg_req.
- flash_mode  in  1  request for night flashing mode.
- car_light  out  3*NUM_DIR  per approach {red,yellow,green}, one-hot; approach i occupies [3i+2:3i].
- walker_light  out  3*NUM_DIR  per approach: 100 DONT_WALK, 010 CLEAR, 001 WALK, 000 dark.
- cur_dir  out  $clog2(NUM_DIR)  approach currently owning the phase.
- state_o  out  3  current FSM state code.

## Operation
- FSM states:
  - ALL_RED=0: every car light red, walkers DONT_WALK.
  - GREEN=1: car cur_dir green, all other approaches red.
  - YELLOW=2: car cur_dir yellow, all other approaches red.
  - EMG_GREEN=3: car emg_dir green, everything else red; all walkers DONT_WALK.
  - FLASH=4: car 0 toggles yellow/000 and the other cars toggle red/000, every FLASH_CYC cycles, starting in the "on" phase; walkers 000.
- Every timed state lasts exactly its *_CYC cycles. The timer loads *_CYC-1 on entry and the state exits in the cycle where the timer reads 0.
- Normal rotation is ALL_RED → GREEN(d) → YELLOW(d) → ALL_RED → GREEN((d+1) mod NUM_DIR).
- Pedestrian requests:
  - ped_req[i] sets ped_pend[i] in any cycle.
  - On the ALL_RED→GREEN(d) edge: serve = ped_pend[d], and ped_pend[d] is loaded with ped_req[d]. A request held across that edge stays pending for the next service.
  - If served, walker d shows WALK for the first WALK_CYC green cycles, then CLEAR for the rest of GREEN and all of YELLOW, then DONT_WALK.
  - If not served, walker d stays DONT_WALK.
  - Walkers of non-owning approaches show DONT_WALK.
- Emergency preemption has top priority. emg_req is sampled each cycle.
  - In GREEN(d) with d≠emg_dir: force YELLOW(d) next cycle with a full YELLOW_CYC, then ALL_RED, then EMG_GREEN.
  - In GREEN(emg_dir): go to EMG_GREEN next cycle.
  - In YELLOW: finish it, then ALL_RED, then EMG_GREEN.
  - In ALL_RED: finish it, then EMG_GREEN.
  - In FLASH: go to ALL_RED next cycle, then EMG_GREEN.
  - EMG_GREEN holds while emg_req=1. On the first cycle with emg_req=0, go to YELLOW(emg_dir) → ALL_RED → GREEN((emg_dir+1) mod NUM_DIR).
  - emg_dir is latched on entry to preemption; later changes are ignored until preemption ends.
  - A served walk in progress is cut to CLEAR when YELLOW is forced.
- Flash mode:
  - flash_mode is checked only when ALL_RED expires. If it is 1 (and emg_req=0), go to FLASH instead of GREEN.
  - FLASH exits at the end of a half-period in which flash_mode=0. The exit path is ALL_RED → GREEN(0).
- ped_pend keeps accumulating in FLASH and EMG_GREEN.

## Timing
- All outputs decode registered state only. There is no combinational path from inputs to outputs.
- An input change in cycle n affects outputs at cycle n+1 at the earliest.
- Reset values (output from the cycle after reset is sampled high):
  - state ALL_RED, cur_dir 0, timer ALL_RED_CYC-1, ped_pend 0, emg latch cleared, flash phase "on".
  - car_light all red (100 each), walker_light all DONT_WALK.
- Reset mid-operation aborts any phase, preemption or flash on the next edge. No yellow is inserted.
- Normal phase period is GREEN_CYC+YELLOW_CYC+ALL_RED_CYC (26 cycles by default); a full cycle is NUM_DIR times that.
- Simultaneous events: reset > emg_req > flash_mode > rotation. ped_req never alters phase timing.

## Structure
- Package tl_pkg holds:
  - the light encodings RED/YELLOW/GREEN and DONT_WALK/CLEAR/WALK/DARK;
  - the state enum codes 0..4;
  - the clog2 helper.
- Sub-module tl_phase_timer: a loadable CNT_W down-counter with load, load_val and a done flag (done = count==0). It is instantiated once.
- The FSM, ped_pend, the emg latch and the output decode live in traffic_ctrl_multi.

## Test plan
All scenarios use default parameters, with cycle 0 as the first cycle after reset deasserts.
- Reset and rotation: cars all red in cycles 0-1; car0 green 2-21, yellow 22-25; all red 26-27; car1 green from 28.
- Pedestrian service: ped_req[1] pulses at cycle 5 → walker1 WALK 28-35, CLEAR 36-51, DONT_WALK from 52. Walker0 stays DONT_WALK at its next green (54) because no request was made.
- Emergency preemption: emg_req=1, emg_dir=1 from cycle 10 → car0 yellow 11-14, all red 15-16, car1 green from 17. Dropping emg_req at cycle 40 gives car1 yellow 41-44, all red 45-46, car0 green from 47.
- Flash mode: flash_mode=1 at cycle 5 → FLASH from 28; car0 yellow 28-32, off 33-37; car1 red/off in step; walkers 000. Clearing flash_mode during 33-37 gives ALL_RED at 38-39 and car0 green at 40.
- Reset mid-yellow: reset high at cycle 23 → cycle 24 all red with ped_pend cleared. After release the sequence restarts exactly as in the reset scenario.
- NUM_DIR=3: green order 0→1→2→0, with phase starts at 2, 28, 54, 80. An emergency with emg_dir=2 during GREEN(2) enters EMG_GREEN with no yellow.
